// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: program counter, IF/ID register, one-word hold buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_INC   = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] held;
  logic [31:0] held_pc4;
  logic [31:0] pc_next_seq;
  logic [31:0] redirect_target;

  // Sequential PC wraps modulo 2^32; redirect targets are forced word-aligned.
  assign pc_next_seq     = PC + 32'(PC_INC);
  assign redirect_target = RedirectPC & ~32'h0000_0003;

  // Requests are only issued while fetching; the address is always the aligned PC.
  assign IMemReq  = (state == S_FETCH);
  assign IMemAddr = PC & ~32'h0000_0003;

  // Fetch FSM: PC, IF/ID register and hold buffer update; redirect overrides stall outside BOOT.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state         <= S_BOOT;
      PC            <= RESET_PC;
      held          <= 32'h0;
      held_pc4      <= 32'h0;
      IF_ID_Instr   <= 32'h0;
      IF_ID_PCPlus4 <= 32'h0;
      IF_ID_Valid   <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (Redirect) begin
            PC          <= redirect_target;
            IF_ID_Valid <= 1'b0;
            state       <= S_FETCH;
          end else if (IMemReady && !Stall) begin
            IF_ID_Instr   <= IMemData;
            IF_ID_PCPlus4 <= pc_next_seq;
            IF_ID_Valid   <= 1'b1;
            PC            <= pc_next_seq;
          end else if (IMemReady && Stall) begin
            // Decode is frozen: park the word so the request is not repeated.
            held     <= IMemData;
            held_pc4 <= pc_next_seq;
            state    <= S_HOLD;
          end else if (!Stall) begin
            IF_ID_Valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (Redirect) begin
            // The parked word belongs to the abandoned path and is dropped.
            PC          <= redirect_target;
            IF_ID_Valid <= 1'b0;
            held        <= 32'h0;
            held_pc4    <= 32'h0;
            state       <= S_FETCH;
          end else if (!Stall) begin
            IF_ID_Instr   <= held;
            IF_ID_PCPlus4 <= held_pc4;
            IF_ID_Valid   <= 1'b1;
            PC            <= pc_next_seq;
            state         <= S_FETCH;
          end
        end
        default: begin
          state <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        Clk;
  logic        Rst;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Stall;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;

  logic        b_req;
  logic [31:0] b_addr;
  logic [31:0] b_data;
  logic [31:0] b_pc;
  logic [31:0] b_instr;
  logic [31:0] b_pc4;
  logic        b_valid;

  int pass_cnt;
  int total_cnt;

  // Memory returns an address-tagged word so each slot is recognisable.
  assign IMemData = IMemAddr ^ 32'hC0DE_0000;
  assign b_data   = b_addr ^ 32'hC0DE_0000;

  fetch_stage #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut (
    .Clk(Clk), .Rst(Rst), .Redirect(Redirect), .RedirectPC(RedirectPC), .Stall(Stall),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
    .PC(PC), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .PC_INC(4)) dut_wrap (
    .Clk(Clk), .Rst(Rst), .Redirect(1'b0), .RedirectPC(32'h0), .Stall(1'b0),
    .IMemReq(b_req), .IMemAddr(b_addr), .IMemReady(1'b1), .IMemData(b_data),
    .PC(b_pc), .IF_ID_Instr(b_instr), .IF_ID_PCPlus4(b_pc4), .IF_ID_Valid(b_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [31:0] pc, input logic req,
                          input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
    check({tag, ".pc"},    PC, pc);
    check({tag, ".req"},   {31'h0, IMemReq}, {31'h0, req});
    check({tag, ".instr"}, IF_ID_Instr, instr);
    check({tag, ".pc4"},   IF_ID_PCPlus4, pc4);
    check({tag, ".valid"}, {31'h0, IF_ID_Valid}, {31'h0, valid});
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    Rst        = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    Stall      = 1'b0;
    IMemReady  = 1'b1;
    #12;
    check_if("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("reset.addr", IMemAddr, 32'h0);
    check("reset_w.pc", b_pc, 32'hFFFF_FFF8);

    // Release; a redirect during BOOT must be ignored.
    @(negedge Clk);
    Rst        = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0040;
    step();
    Redirect = 1'b0;
    check_if("boot", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    check("boot.addr", IMemAddr, 32'h0);
    check("boot_w.pc", b_pc, 32'hFFFF_FFF8);

    step();
    check_if("seq0", 32'h4, 1'b1, 32'hC0DE_0000, 32'h4, 1'b1);
    check("seq0.addr", IMemAddr, 32'h4);
    check("seq0_w.pc", b_pc, 32'hFFFF_FFFC);
    check("seq0_w.pc4", b_pc4, 32'hFFFF_FFFC);

    step();
    check_if("seq1", 32'h8, 1'b1, 32'hC0DE_0004, 32'h8, 1'b1);
    check("seq1_w.pc", b_pc, 32'h0000_0000);
    check("seq1_w.pc4", b_pc4, 32'h0000_0000);
    check("seq1_w.instr", b_instr, 32'h3F21_FFFC);

    // Stall three cycles with the word at 8 ready.
    Stall = 1'b1;
    step();
    check_if("hold0", 32'h8, 1'b0, 32'hC0DE_0004, 32'h8, 1'b1);
    check("hold0.addr", IMemAddr, 32'h8);
    step();
    check_if("hold1", 32'h8, 1'b0, 32'hC0DE_0004, 32'h8, 1'b1);
    step();
    check_if("hold2", 32'h8, 1'b0, 32'hC0DE_0004, 32'h8, 1'b1);
    Stall = 1'b0;
    step();
    check_if("unhold", 32'hC, 1'b1, 32'hC0DE_0008, 32'hC, 1'b1);

    step();
    check_if("seq2", 32'h10, 1'b1, 32'hC0DE_000C, 32'h10, 1'b1);

    // Memory wait states at PC 0x10.
    IMemReady = 1'b0;
    step();
    check_if("wait0", 32'h10, 1'b1, 32'hC0DE_000C, 32'h10, 1'b0);
    step();
    check_if("wait1", 32'h10, 1'b1, 32'hC0DE_000C, 32'h10, 1'b0);
    IMemReady = 1'b1;
    step();
    check_if("resume", 32'h14, 1'b1, 32'hC0DE_0010, 32'h14, 1'b1);

    // Redirect while stalled in HOLD flushes the held word.
    Stall = 1'b1;
    step();
    check_if("hold3", 32'h14, 1'b0, 32'hC0DE_0010, 32'h14, 1'b1);
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0103;
    step();
    Redirect = 1'b0;
    Stall    = 1'b0;
    check_if("redir_hold", 32'h100, 1'b1, 32'hC0DE_0010, 32'h14, 1'b0);
    check("redir_hold.addr", IMemAddr, 32'h100);
    step();
    check_if("after_redir", 32'h104, 1'b1, 32'hC0DE_0100, 32'h104, 1'b1);

    // Redirect in FETCH drops the same-cycle ready data.
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0200;
    step();
    Redirect = 1'b0;
    check_if("redir_fetch", 32'h200, 1'b1, 32'hC0DE_0100, 32'h104, 1'b0);

    // Asynchronous reset between edges while holding.
    Stall = 1'b1;
    step();
    check_if("hold4", 32'h200, 1'b0, 32'hC0DE_0100, 32'h104, 1'b0);
    #2;
    Rst = 1'b0;
    #1;
    check_if("async_rst", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge Clk);
    Rst   = 1'b1;
    Stall = 1'b0;
    step();
    check_if("rerelease", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    check("rerelease.addr", IMemAddr, 32'h0);
    step();
    check_if("refetch", 32'h4, 1'b1, 32'hC0DE_0000, 32'h4, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that owns the program counter and the IF/ID pipeline register.
- Takes the next-PC redirect target from the branch/jump 32-bit 2:1 select immediately upstream.
- Issues requests to a variable-latency instruction memory and holds one fetched word when the pipeline stalls.
- Presents instruction, PC+4 and a valid bit to the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
PC_INC, 4, sequential increment in bytes.

Ports:
Clk  input  1  clock, rising-edge.
Rst  input  1  asynchronous active-low reset.
Redirect  input  1  take RedirectPC this cycle (branch/jump resolved).
RedirectPC  input  32  redirect target from upstream select.
Stall  input  1  hazard unit holds IF/ID contents.
IMemReq  output  1  fetch request valid.
IMemAddr  output  32  fetch address (word-aligned).
IMemReady  input  1  IMemData valid for current IMemAddr this cycle.
IMemData  input  32  fetched instruction.
PC  output  32  current fetch PC.
IF_ID_Instr  output  32  registered instruction to decode.
IF_ID_PCPlus4  output  32  registered PC+PC_INC of that instruction.
IF_ID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (Rst=0, async):
  - PC=RESET_PC.
  - IF_ID_Instr=0, IF_ID_PCPlus4=0, IF_ID_Valid=0.
  - Held buffer cleared; state=BOOT.
  - IMemReq=0 while in reset and in BOOT.
- States: BOOT, FETCH, HOLD.
  - BOOT → FETCH unconditionally on the first clock edge after reset release.
- IMemAddr = {PC[31:2],2'b00} in all states.
  - IMemReq=1 only in FETCH.
- FETCH:
  - IMemReady=1, Stall=0: IF_ID_Instr<=IMemData, IF_ID_PCPlus4<=PC+PC_INC, IF_ID_Valid<=1, PC<=PC+PC_INC; stay FETCH.
  - IMemReady=1, Stall=1: Held<=IMemData and HeldPC4<=PC+PC_INC; IF/ID unchanged; PC unchanged; →HOLD.
  - IMemReady=0, Stall=0: IF_ID_Valid<=0 (bubble), Instr/PCPlus4 unchanged; PC unchanged.
  - IMemReady=0, Stall=1: everything unchanged.
- HOLD (no request issued):
  - Stall=1: stay.
  - Stall=0: IF_ID <= Held/HeldPC4, IF_ID_Valid<=1, PC<=PC+PC_INC; →FETCH.
- Redirect=1 has top priority in any state except BOOT, and overrides Stall:
  - PC<={RedirectPC[31:2],2'b00}.
  - IF_ID_Valid<=0 (flush).
  - Held buffer discarded.
  - Any same-cycle IMemReady data dropped.
  - Next state FETCH.
- Redirect in BOOT: ignored.
- Arithmetic: PC+PC_INC is 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0000_0000; no overflow flag.
- Latency: an instruction whose IMemReady arrives at edge N appears on IF_ID_* after edge N, absent stall or redirect.
- Throughput: one instruction per cycle with zero-wait memory.
- Memory contract: IMemReady always refers to the IMemAddr of the same cycle; an address change (redirect) implicitly cancels prior requests.
- Assertion of Rst mid-request or in HOLD clears all state immediately; the held instruction is lost.

Test Plan:
- Reset release, IMemReady=1 every cycle, IMemData=addr-derived: IMemAddr sequence 0,4,8,C. IF_ID_Instr lags one cycle. IF_ID_PCPlus4 = 4,8,C,10. IF_ID_Valid=1 from second edge.
- IMemReady=1 at PC=8 with Stall=1 for 3 cycles:
  - →HOLD, IMemReq=0, IF_ID frozen, PC stays 8.
  - When Stall drops, IF_ID_Instr = word@8, IF_ID_PCPlus4=C, PC=C.
- Redirect=1 with RedirectPC=32'h0000_0103 while Stall=1 in HOLD:
  - Next cycle PC=0x100, IF_ID_Valid=0, state FETCH.
  - Held word never appears on IF_ID.
- IMemReady low 2 cycles at PC=0x10, Stall=0: IF_ID_Valid=0 for those cycles, PC stays 0x10, then resumes.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory: PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; IF_ID_PCPlus4 for FFFF_FFFC is 0.
- Rst asserted asynchronously mid-HOLD (between edges): all outputs reach reset values immediately. First request after release is at RESET_PC.
